// File: rtl/branch_predict_unit_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter, per-entry
// control bits and the saturating counter helpers.
package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  // Tag and target live in separate arrays so their widths can follow DataWidth.
  typedef struct packed {
    logic valid;
    logic is_jump;
    ctr_e ctr;
  } btb_entry_t;

  localparam btb_entry_t BtbEntryReset = '{valid: 1'b0, is_jump: 1'b0, ctr: WNT};

  function automatic ctr_e ctr_inc(input ctr_e c);
    return (c == ST) ? ST : ctr_e'(2'(c) + 2'd1);
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    return (c == SNT) ? SNT : ctr_e'(2'(c) - 2'd1);
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Connection between the predictor datapath (master) and the table storage
// (slave): one combinational lookup port and one resolve-update port.
interface bpu_table_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Entries   = 16
);
  import bpu_pkg::*;

  localparam int unsigned IdxW = $clog2(Entries);
  localparam int unsigned TagW = DataWidth - IdxW - 2;

  logic [IdxW-1:0]      rd_idx;
  logic [TagW-1:0]      rd_tag;
  logic                 rd_hit;
  logic                 rd_is_jump;
  ctr_e                 rd_ctr;
  logic [DataWidth-1:0] rd_target;

  // upd_valid is a one-cycle strobe; no backpressure, the table always accepts.
  logic                 upd_valid;
  logic [IdxW-1:0]      upd_idx;
  logic [TagW-1:0]      upd_tag;
  logic                 upd_taken;
  logic                 upd_is_jump;
  logic [DataWidth-1:0] upd_target;

  modport master (
    output rd_idx, rd_tag, upd_valid, upd_idx, upd_tag, upd_taken, upd_is_jump, upd_target,
    input  rd_hit, rd_is_jump, rd_ctr, rd_target
  );

  modport slave (
    input  rd_idx, rd_tag, upd_valid, upd_idx, upd_tag, upd_taken, upd_is_jump, upd_target,
    output rd_hit, rd_is_jump, rd_ctr, rd_target
  );
endinterface

// File: rtl/branch_target_table.sv
// Direct-mapped BHT/BTB storage: combinational lookup, read-modify-write
// update on the clock edge after a resolve.
module branch_target_table
  import bpu_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Entries   = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  bpu_table_if.slave   tbl
);

  localparam int unsigned IdxW = $clog2(Entries);
  localparam int unsigned TagW = DataWidth - IdxW - 2;

  btb_entry_t           entry_q  [Entries];
  logic [TagW-1:0]      tag_q    [Entries];
  logic [DataWidth-1:0] target_q [Entries];

  btb_entry_t entry_d;
  logic       upd_hit;

  assign tbl.rd_hit     = entry_q[tbl.rd_idx].valid && (tag_q[tbl.rd_idx] == tbl.rd_tag);
  assign tbl.rd_is_jump = entry_q[tbl.rd_idx].is_jump;
  assign tbl.rd_ctr     = entry_q[tbl.rd_idx].ctr;
  assign tbl.rd_target  = target_q[tbl.rd_idx];

  assign upd_hit = entry_q[tbl.upd_idx].valid && (tag_q[tbl.upd_idx] == tbl.upd_tag);

  always_comb begin
    entry_d = entry_q[tbl.upd_idx];
    if (upd_hit) begin
      entry_d.ctr = tbl.upd_taken ? ctr_inc(entry_q[tbl.upd_idx].ctr)
                                  : ctr_dec(entry_q[tbl.upd_idx].ctr);
      if (tbl.upd_taken) entry_d.is_jump = tbl.upd_is_jump;
    end else if (tbl.upd_taken) begin
      entry_d = '{valid: 1'b1, is_jump: tbl.upd_is_jump, ctr: WT};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Entries); i++) entry_q[i] <= BtbEntryReset;
    end else if (tbl.upd_valid) begin
      entry_q[tbl.upd_idx] <= entry_d;
    end
  end

  // Tag/target need no reset: they are only trusted behind a set valid bit.
  always_ff @(posedge clk_i) begin
    if (tbl.upd_valid && tbl.upd_taken) begin
      tag_q[tbl.upd_idx]    <= tbl.upd_tag;
      target_q[tbl.upd_idx] <= tbl.upd_target;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: fetch-side lookup, execute-side resolve with
// mispredict detection, registered redirect and mispredict statistics.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Entries   = 16,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] fetch_pc_i,
  output logic                 pred_taken_o,
  output logic [DataWidth-1:0] pred_target_o,
  input  logic                 res_valid_i,
  input  logic                 res_jal_i,
  input  logic                 res_jalr_i,
  input  logic                 res_branch_i,
  input  logic                 res_cond_i,
  input  logic [DataWidth-1:0] res_pc_i,
  input  logic [DataWidth-1:0] res_rs1_data_i,
  input  logic [DataWidth-1:0] res_offset_i,
  input  logic                 res_pred_taken_i,
  input  logic [DataWidth-1:0] res_pred_target_i,
  output logic                 redirect_o,
  output logic [DataWidth-1:0] redirect_pc_o,
  output logic [CntWidth-1:0]  mispredict_cnt_o
);

  localparam int unsigned IdxW = $clog2(Entries);

  bpu_table_if #(.DataWidth(DataWidth), .Entries(Entries)) tbl_if ();

  branch_target_table #(.DataWidth(DataWidth), .Entries(Entries)) u_table (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tbl    (tbl_if.slave)
  );

  logic                 res_active;
  logic                 res_taken;
  logic [DataWidth-1:0] res_sum;
  logic [DataWidth-1:0] res_target;
  logic                 mispredict;

  logic                 redirect_q,    redirect_d;
  logic [DataWidth-1:0] redirect_pc_q, redirect_pc_d;
  logic [CntWidth-1:0]  cnt_q,         cnt_d;

  // Lookup
  assign tbl_if.rd_idx  = fetch_pc_i[IdxW+1:2];
  assign tbl_if.rd_tag  = fetch_pc_i[DataWidth-1:IdxW+2];
  assign pred_taken_o   = tbl_if.rd_hit && (tbl_if.rd_is_jump || (tbl_if.rd_ctr >= WT));
  assign pred_target_o  = pred_taken_o ? tbl_if.rd_target : fetch_pc_i + DataWidth'(4);

  // Resolve: a valid beat without any type bit is treated as a bubble.
  assign res_active = res_valid_i && (res_jal_i || res_jalr_i || res_branch_i);
  assign res_taken  = res_jal_i || res_jalr_i || (res_branch_i && res_cond_i);
  assign res_sum    = (res_jalr_i ? res_rs1_data_i : res_pc_i) + res_offset_i;
  assign res_target = res_jalr_i ? {res_sum[DataWidth-1:1], 1'b0} : res_sum;

  assign mispredict = res_active &&
                      ((res_taken != res_pred_taken_i) ||
                       (res_taken && (res_target != res_pred_target_i)));

  assign tbl_if.upd_valid   = res_active;
  assign tbl_if.upd_idx     = res_pc_i[IdxW+1:2];
  assign tbl_if.upd_tag     = res_pc_i[DataWidth-1:IdxW+2];
  assign tbl_if.upd_taken   = res_taken;
  assign tbl_if.upd_is_jump = res_jal_i || res_jalr_i;
  assign tbl_if.upd_target  = res_target;

  always_comb begin
    redirect_d    = mispredict;
    redirect_pc_d = redirect_pc_q;
    cnt_d         = cnt_q;
    if (mispredict) begin
      redirect_pc_d = res_taken ? res_target : res_pc_i + DataWidth'(4);
      if (cnt_q != '1) cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      cnt_q         <= '0;
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign redirect_o       = redirect_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign mispredict_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by
// random resolves, checked against an array-based predictor model.
module tb_branch_predict_unit;

  localparam int ENTRIES = 16;
  localparam int K_NONE = 0, K_JAL = 1, K_JALR = 2, K_BR = 3, K_VALID_ONLY = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        res_valid = 0, res_jal = 0, res_jalr = 0, res_branch = 0, res_cond = 0;
  logic [31:0] res_pc = '0, res_rs1 = '0, res_off = '0;
  logic        res_ptaken = 0;
  logic [31:0] res_ptarget = '0;

  logic        pred_taken, redirect;
  logic [31:0] pred_target, redirect_pc;
  logic [15:0] cnt;
  logic        pred_taken2, redirect2;
  logic [31:0] pred_target2, redirect_pc2;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  branch_predict_unit #(.DataWidth(32), .Entries(ENTRIES), .CntWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_pc_i(fetch_pc),
    .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .res_valid_i(res_valid), .res_jal_i(res_jal), .res_jalr_i(res_jalr),
    .res_branch_i(res_branch), .res_cond_i(res_cond), .res_pc_i(res_pc),
    .res_rs1_data_i(res_rs1), .res_offset_i(res_off),
    .res_pred_taken_i(res_ptaken), .res_pred_target_i(res_ptarget),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc), .mispredict_cnt_o(cnt)
  );

  branch_predict_unit #(.DataWidth(32), .Entries(ENTRIES), .CntWidth(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .fetch_pc_i(fetch_pc),
    .pred_taken_o(pred_taken2), .pred_target_o(pred_target2),
    .res_valid_i(res_valid), .res_jal_i(res_jal), .res_jalr_i(res_jalr),
    .res_branch_i(res_branch), .res_cond_i(res_cond), .res_pc_i(res_pc),
    .res_rs1_data_i(res_rs1), .res_offset_i(res_off),
    .res_pred_taken_i(res_ptaken), .res_pred_target_i(res_ptarget),
    .redirect_o(redirect2), .redirect_pc_o(redirect_pc2), .mispredict_cnt_o(cnt2)
  );

  // Reference predictor state
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  bit          m_jump  [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_miss_total;
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_jump[i] = 0; m_ctr[i] = 1; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_miss_total = 0;
    exp_q.delete();
  endtask

  task automatic model_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
    int i;
    bit hit;
    i   = int'((pc / 4) % ENTRIES);
    hit = m_valid[i] && (m_tag[i] == pc / (4 * ENTRIES));
    t   = hit && (m_jump[i] || m_ctr[i] >= 2);
    tgt = t ? m_tgt[i] : pc + 32'd4;
  endtask

  // One cycle: drive fetch + resolve, check lookup, then check the registered redirect.
  task automatic run(input logic [31:0] fpc, input int kind, input bit cond,
                     input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] off,
                     input bit auto_pred, input bit ptk, input logic [31:0] ptg);
    bit          et, taken, active, mis, hit;
    logic [31:0] etg, target;
    int          i;
    @(negedge clk);
    if (auto_pred) model_lookup(pc, ptk, ptg);
    fetch_pc   = fpc;
    res_valid  = (kind != K_NONE);
    res_jal    = (kind == K_JAL);
    res_jalr   = (kind == K_JALR);
    res_branch = (kind == K_BR);
    res_cond   = cond;
    res_pc = pc; res_rs1 = rs1; res_off = off;
    res_ptaken = ptk; res_ptarget = ptg;
    #1;
    model_lookup(fpc, et, etg);
    check("pred_taken", {31'b0, pred_taken}, {31'b0, et});
    check("pred_target", pred_target, etg);

    active = (kind == K_JAL) || (kind == K_JALR) || (kind == K_BR);
    taken  = (kind == K_JAL) || (kind == K_JALR) || ((kind == K_BR) && cond);
    target = ((kind == K_JALR) ? rs1 : pc) + off;
    if (kind == K_JALR) target = target & 32'hFFFF_FFFE;
    mis = active && ((taken != ptk) || (taken && target != ptg));
    if (mis) begin
      exp_q.push_back(taken ? target : pc + 32'd4);
      m_miss_total++;
    end

    @(posedge clk);
    #1;
    if (active) begin
      i   = int'((pc / 4) % ENTRIES);
      hit = m_valid[i] && (m_tag[i] == pc / (4 * ENTRIES));
      if (hit) begin
        m_ctr[i] = taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (taken) begin m_tgt[i] = target; m_jump[i] = (kind != K_BR); end
      end else if (taken) begin
        m_valid[i] = 1; m_tag[i] = pc / (4 * ENTRIES); m_tgt[i] = target;
        m_jump[i] = (kind != K_BR); m_ctr[i] = 2;
      end
    end
    check("redirect", {31'b0, redirect}, {31'b0, mis});
    check("redirect_sat", {31'b0, redirect2}, {31'b0, mis});
    if (mis && exp_q.size() > 0) begin
      etg = exp_q.pop_front();
      check("redirect_pc", redirect_pc, etg);
      check("redirect_pc_sat", redirect_pc2, etg);
    end
    check("mispredict_cnt", {16'b0, cnt}, (m_miss_total > 65535) ? 32'd65535 : 32'(m_miss_total));
    check("mispredict_cnt_sat", {30'b0, cnt2}, (m_miss_total > 3) ? 32'd3 : 32'(m_miss_total));
  endtask

  task automatic lookup_only(input logic [31:0] fpc);
    run(fpc, K_NONE, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  initial begin
    bit          ptk;
    logic [31:0] ptg, pc, rs1, off;
    int          kind;

    // Reset
    model_reset();
    rst_n = 1'b0;
    fetch_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
    check("rst_pred_target", pred_target, 32'h104);
    check("rst_redirect", {31'b0, redirect}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_cnt", {16'b0, cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // BEQ at 0x100 taken, predicted not taken; lookup in the same cycle sees the old entry
    run(32'h100, K_BR, 1, 32'h100, 32'h0, 32'h20, 0, 0, 32'h104);
    run(32'h100, K_BR, 1, 32'h100, 32'h0, 32'h20, 1, 0, 32'h0);
    run(32'h100, K_BR, 1, 32'h100, 32'h0, 32'h20, 1, 0, 32'h0);
    lookup_only(32'h100);
    // Three not-taken, then one more at the floor, then one taken must stay not-taken
    repeat (4) run(32'h100, K_BR, 0, 32'h100, 32'h0, 32'h20, 1, 0, 32'h0);
    run(32'h100, K_BR, 1, 32'h100, 32'h0, 32'h20, 1, 0, 32'h0);
    lookup_only(32'h100);

    // JALR target arithmetic with bit 0 cleared
    run(32'h40, K_JALR, 0, 32'h40, 32'h1003, 32'h4, 0, 0, 32'h0);
    run(32'h40, K_JALR, 0, 32'h40, 32'h1000, 32'h5, 1, 1, 32'h1000);
    lookup_only(32'h40);

    // Aliasing: 0x100 + 4*Entries evicts 0x100
    run(32'h100, K_JAL, 0, 32'h100, 32'h0, 32'h80, 1, 0, 32'h0);
    run(32'h100 + 4 * ENTRIES, K_JAL, 0, 32'h100 + 4 * ENTRIES, 32'h0, 32'h40, 1, 0, 32'h0);
    lookup_only(32'h100);
    lookup_only(32'h100 + 4 * ENTRIES);

    // Back-to-back correct predictions: no redirect, counter unchanged
    for (int k = 0; k < 6; k++)
      run(32'h300, K_JAL, 0, 32'h140, 32'h0, 32'h40, 1, 0, 32'h0);

    // Back-to-back mispredicts with distinct PCs
    run(32'h0, K_BR, 0, 32'h500, 32'h0, 32'h10, 0, 1, 32'h510);
    run(32'h0, K_BR, 0, 32'h504, 32'h0, 32'h10, 0, 1, 32'h514);
    run(32'h0, K_JAL, 0, 32'h508, 32'h0, 32'h30, 0, 0, 32'h50C);
    run(32'h0, K_VALID_ONLY, 1, 32'h50C, 32'h0, 32'h30, 0, 1, 32'h0);

    // Reset while a redirect is pending
    @(negedge clk);
    fetch_pc = 32'h200; res_valid = 1; res_jal = 0; res_jalr = 0; res_branch = 1; res_cond = 1;
    res_pc = 32'h200; res_off = 32'h40; res_ptaken = 0; res_ptarget = 32'h204;
    @(posedge clk);
    #1;
    check("pend_redirect", {31'b0, redirect}, 32'd1);
    check("pend_redirect_pc", redirect_pc, 32'h240);
    rst_n = 1'b0;
    #1;
    check("rst_mid_redirect", {31'b0, redirect}, 32'd0);
    check("rst_mid_cnt", {16'b0, cnt}, 32'd0);
    check("rst_mid_cnt_sat", {30'b0, cnt2}, 32'd0);
    model_reset();
    @(negedge clk);
    res_valid = 0; res_branch = 0;
    rst_n = 1'b1;
    lookup_only(32'h200);
    lookup_only(32'h100 + 4 * ENTRIES);

    // Five mispredicts after reset: the 2-bit counter holds at 3
    for (int k = 0; k < 5; k++)
      run(32'h0, K_BR, 1, 32'h600 + 32'(k * 4), 32'h0, 32'h8, 0, 0, 32'h0);

    // Random resolves against the model
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0:       kind = K_NONE;
        1:       kind = K_VALID_ONLY;
        2, 3:    kind = K_JAL;
        4, 5:    kind = K_JALR;
        default: kind = K_BR;
      endcase
      pc  = 32'h100 + 32'($urandom_range(0, 47) * 4);
      rs1 = 32'h1000 + 32'($urandom_range(0, 255));
      off = 32'($urandom_range(0, 63) * 4);
      model_lookup(pc, ptk, ptg);
      if ($urandom_range(0, 3) == 0) ptk = ~ptk;
      if ($urandom_range(0, 3) == 0) ptg = ptg + 32'd4;
      run(32'h100 + 32'($urandom_range(0, 47) * 4), kind, 1'($urandom_range(0, 1)),
          pc, rs1, off, 0, ptk, ptg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
